// File: rtl/decode_queue.sv
// In-order instruction queue between fetch and dispatch; presents the oldest
// entry split into opcode/rd/rs fields plus branch and writeback flags.
module decode_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_valid,
  output logic                   f_ready,
  input  logic [7:0]             f_pc,
  input  logic [7:0]             f_instr,
  input  logic                   flush,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [7:0]             d_pc,
  output logic [3:0]             d_opcode,
  output logic [1:0]             d_rd,
  output logic [1:0]             d_rs,
  output logic                   d_is_branch,
  output logic                   d_writes_rd,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  ptr_t       wr_q, wr_d;
  ptr_t       rd_q, rd_d;
  cnt_t       count_q, count_d;
  logic [7:0] pc_q    [DEPTH];
  logic [7:0] instr_q [DEPTH];
  logic       enq, deq;
  logic [7:0] head_instr;

  // f_ready looks only at occupancy, so a full queue never accepts even on a pop.
  assign f_ready = (count_q < Full);
  assign d_valid = (count_q != '0);
  assign enq     = f_valid && f_ready;
  assign deq     = d_valid && d_ready;
  assign count   = count_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (enq) wr_d = wr_q + ptr_t'(1);
      if (deq) rd_d = rd_q + ptr_t'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head fields read zero; a flush leaves it intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (enq && !flush) begin
      pc_q[wr_q]    <= f_pc;
      instr_q[wr_q] <= f_instr;
    end
  end

  assign head_instr  = instr_q[rd_q];
  assign d_pc        = pc_q[rd_q];
  assign d_opcode    = head_instr[7:4];
  assign d_rd        = head_instr[3:2];
  assign d_rs        = head_instr[1:0];
  assign d_is_branch = (head_instr[7:5] == 3'b111);
  assign d_writes_rd = (head_instr[7:4] < 4'hC);

endmodule
